share_filter: RTL and testbench

- Sequential leading-zero qualifier for mined hashes; sits downstream of the hash cores and upstream of the nonce-report/host interface.
- Accepts (hash, nonce) pairs over a valid/ready stream and scans each hash MSB-first, CHUNK_W bits per cycle.
- Emits the nonce over a valid/ready result stream when the hash has at least `difficulty` leading zeros.
- Keeps running statistics: best zero count, best nonce and hashes checked.

---
 rtl/share_filter_if.sv | 24 ++
 rtl/share_filter.sv | 113 +++++++++++
 tb/tb_share_filter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/share_filter_if.sv
// rtl/share_filter_if.sv - valid/ready hash input and result output streams of the share filter
interface share_filter_if #(
  parameter int HASH_W  = 256,
  parameter int NONCE_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [HASH_W-1:0]  in_hash;
  logic [NONCE_W-1:0] in_nonce;
  logic               out_valid;
  logic               out_ready;
  logic [NONCE_W-1:0] out_nonce;
  logic [31:0]        out_zeros;

  modport master (
    output in_valid, in_hash, in_nonce, out_ready,
    input  in_ready, out_valid, out_nonce, out_zeros
  );

  modport slave (
    input  in_valid, in_hash, in_nonce, out_ready,
    output in_ready, out_valid, out_nonce, out_zeros
  );
endinterface

// File: rtl/share_filter.sv
// rtl/share_filter.sv - chunked MSB-first leading-zero qualifier for mined hashes with running stats
module share_filter #(
  parameter int HASH_W  = 256,
  parameter int NONCE_W = 32,
  parameter int CHUNK_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        difficulty,
  input  logic               clear_stats,
  share_filter_if.slave      s,
  output logic [31:0]        best_zeros,
  output logic [NONCE_W-1:0] best_nonce,
  output logic [31:0]        hash_count
);
  localparam int NCHUNK = HASH_W / CHUNK_W;

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t             state;
  logic [HASH_W-1:0]  hash_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [31:0]        diff_q;
  logic [31:0]        count_q;
  logic [31:0]        chunk_idx;
  logic [CHUNK_W-1:0] chunk;
  logic [31:0]        chunk_lz;
  logic [31:0]        total;
  logic               last_chunk;
  logic               finish;

  // hash_q is shifted left each scan cycle, so the chunk under test is always the top slice
  always_comb begin
    chunk    = hash_q[HASH_W-1 -: CHUNK_W];
    chunk_lz = 32'(CHUNK_W);
    for (int i = 0; i < CHUNK_W; i++) begin
      if (chunk[i]) chunk_lz = 32'(CHUNK_W - 1 - i);
    end
    last_chunk = (chunk_idx == 32'(NCHUNK - 1));
    finish     = (state == SCAN) && ((chunk != '0) || last_chunk);
    total      = count_q + chunk_lz;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      s.in_ready  <= 1'b0;
      s.out_valid <= 1'b0;
      s.out_nonce <= '0;
      s.out_zeros <= '0;
      hash_q      <= '0;
      nonce_q     <= '0;
      diff_q      <= '0;
      count_q     <= '0;
      chunk_idx   <= '0;
      best_zeros  <= '0;
      best_nonce  <= '0;
      hash_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s.in_valid && s.in_ready) begin
            hash_q     <= s.in_hash;
            nonce_q    <= s.in_nonce;
            diff_q     <= difficulty;
            count_q    <= '0;
            chunk_idx  <= '0;
            s.in_ready <= 1'b0;
            state      <= SCAN;
          end else begin
            s.in_ready <= 1'b1;
          end
        end
        SCAN: begin
          if (!finish) begin
            count_q   <= total;
            chunk_idx <= chunk_idx + 32'd1;
            hash_q    <= hash_q << CHUNK_W;
          end else if (total >= diff_q) begin
            s.out_valid <= 1'b1;
            s.out_nonce <= nonce_q;
            s.out_zeros <= total;
            state       <= REPORT;
          end else begin
            s.in_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        REPORT: begin
          if (s.out_ready) begin
            s.out_valid <= 1'b0;
            s.in_ready  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A clear on the finishing edge wins: the hash is neither counted nor ranked
      if (clear_stats) begin
        best_zeros <= '0;
        best_nonce <= '0;
        hash_count <= '0;
      end else if (finish) begin
        hash_count <= hash_count + 32'd1;
        if (total > best_zeros) begin
          best_zeros <= total;
          best_nonce <= nonce_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_share_filter.sv
// tb/tb_share_filter.sv - randomized self-checking bench for share_filter against a bit-level reference model
module tb_share_filter;
  localparam int HASH_W  = 256;
  localparam int NONCE_W = 32;
  localparam int CHUNK_W = 32;
  localparam int NCHUNK  = HASH_W / CHUNK_W;
  localparam logic [HASH_W-1:0] H40 = {48'h0000_0000_00F0, 208'h0};

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        difficulty;
  logic               clear_stats;
  logic [31:0]        best_zeros;
  logic [NONCE_W-1:0] best_nonce;
  logic [31:0]        hash_count;

  share_filter_if #(.HASH_W(HASH_W), .NONCE_W(NONCE_W)) bus ();

  share_filter #(.HASH_W(HASH_W), .NONCE_W(NONCE_W), .CHUNK_W(CHUNK_W)) dut (
    .clk(clk), .rst(rst), .difficulty(difficulty), .clear_stats(clear_stats),
    .s(bus), .best_zeros(best_zeros), .best_nonce(best_nonce), .hash_count(hash_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int                 m_best;
  logic [NONCE_W-1:0] m_bnonce;
  logic [31:0]        m_cnt;

  function automatic int ref_lz(input logic [HASH_W-1:0] h);
    for (int i = HASH_W - 1; i >= 0; i--) if (h[i]) return HASH_W - 1 - i;
    return HASH_W;
  endfunction

  function automatic int ref_cycles(input int lz);
    int k = lz / CHUNK_W;
    if (k > NCHUNK - 1) k = NCHUNK - 1;
    return k + 1;
  endfunction

  function automatic logic [HASH_W-1:0] mk_hash(input int lz);
    logic [HASH_W-1:0] h;
    for (int i = 0; i < HASH_W / 32; i++) h[i*32 +: 32] = $urandom;
    h[HASH_W-1] = 1'b1;
    if (lz >= HASH_W) return '0;
    return h >> lz;
  endfunction

  task automatic model_clear();
    m_best = 0; m_bnonce = '0; m_cnt = '0;
  endtask

  task automatic model_finish(input int lz, input logic [NONCE_W-1:0] n);
    m_cnt = m_cnt + 32'd1;
    if (lz > m_best) begin m_best = lz; m_bnonce = n; end
  endtask

  task automatic accept(input logic [HASH_W-1:0] h, input logic [NONCE_W-1:0] n, input logic [31:0] d);
    int w = 0;
    bus.in_valid = 1'b1; bus.in_hash = h; bus.in_nonce = n; difficulty = d;
    while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
    if (!bus.in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_finish(output int cyc);
    cyc = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (bus.out_valid || bus.in_ready) begin cyc = c; break; end
    end
    if (cyc == 0) begin
      n_cmp++; n_err++;
      $display("FAIL finish_timeout: no finish within 400 cycles, required one");
    end
  endtask

  task automatic run_hash(input logic [HASH_W-1:0] h, input logic [NONCE_W-1:0] n, input logic [31:0] d,
                          output int cyc, output bit q, output logic [31:0] z, output logic [NONCE_W-1:0] on);
    accept(h, n, d);
    difficulty = $urandom;
    wait_finish(cyc);
    q = bus.out_valid; z = bus.out_zeros; on = bus.out_nonce;
    model_finish(ref_lz(h), n);
    if (q) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_stats = 1'b0; difficulty = '0;
    bus.in_valid = 1'b0; bus.in_hash = '0; bus.in_nonce = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %0b expected 0", bus.in_ready); end
    n_cmp++; if ({bus.out_valid, bus.out_nonce, bus.out_zeros} !== '0) begin n_err++;
      $display("FAIL reset_out: got v=%0b n=%0h z=%0d expected 0", bus.out_valid, bus.out_nonce, bus.out_zeros); end
    n_cmp++; if ({best_zeros, best_nonce, hash_count} !== '0) begin n_err++;
      $display("FAIL reset_stats: got best=%0d nonce=%0h cnt=%0d expected 0", best_zeros, best_nonce, hash_count); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %0b expected 1", bus.in_ready); end
    model_clear();
  endtask

  task automatic test_basic();
    int cyc; bit q; logic [31:0] z; logic [NONCE_W-1:0] on;
    run_hash(H40, 32'h11, 32'd40, cyc, q, z, on);
    n_cmp++; if (cyc !== 2) begin n_err++; $display("FAIL basic_latency: got %0d expected 2", cyc); end
    n_cmp++; if (q !== 1'b1 || z !== 32'd40 || on !== 32'h11) begin n_err++;
      $display("FAIL basic_result: got v=%0b z=%0d n=%0h expected v=1 z=40 n=11", q, z, on); end
    n_cmp++; if (best_zeros !== 32'd40 || best_nonce !== 32'h11 || hash_count !== 32'd1) begin n_err++;
      $display("FAIL basic_stats: got best=%0d nonce=%0h cnt=%0d expected 40/11/1", best_zeros, best_nonce, hash_count); end
  endtask

  task automatic test_diff_miss();
    int cyc; bit q; logic [31:0] z; logic [NONCE_W-1:0] on;
    run_hash(H40, 32'h22, 32'd41, cyc, q, z, on);
    n_cmp++; if (q !== 1'b0 || cyc !== 2) begin n_err++;
      $display("FAIL diff41: got v=%0b cyc=%0d expected v=0 cyc=2", q, cyc); end
    n_cmp++; if (best_zeros !== 32'd40 || best_nonce !== 32'h11 || hash_count !== 32'd2) begin n_err++;
      $display("FAIL diff41_stats: got best=%0d nonce=%0h cnt=%0d expected 40/11/2", best_zeros, best_nonce, hash_count); end
  endtask

  task automatic test_extremes();
    int cyc; bit q; logic [31:0] z; logic [NONCE_W-1:0] on;
    run_hash('0, 32'h33, 32'd256, cyc, q, z, on);
    n_cmp++; if (cyc !== 8 || q !== 1'b1 || z !== 32'd256 || on !== 32'h33) begin n_err++;
      $display("FAIL all_zero: got cyc=%0d v=%0b z=%0d n=%0h expected 8/1/256/33", cyc, q, z, on); end
    run_hash({1'b1, 255'h0}, 32'h44, 32'd0, cyc, q, z, on);
    n_cmp++; if (cyc !== 1 || q !== 1'b1 || z !== 32'd0 || on !== 32'h44) begin n_err++;
      $display("FAIL msb_set: got cyc=%0d v=%0b z=%0d n=%0h expected 1/1/0/44", cyc, q, z, on); end
    n_cmp++; if (best_zeros !== 32'd256 || best_nonce !== 32'h33 || hash_count !== 32'd4) begin n_err++;
      $display("FAIL extremes_stats: got best=%0d nonce=%0h cnt=%0d expected 256/33/4", best_zeros, best_nonce, hash_count); end
  endtask

  task automatic test_backpressure();
    int cyc; bit stable = 1'b1;
    bus.out_ready = 1'b0;
    accept(mk_hash(10), 32'h55, 32'd5);
    wait_finish(cyc);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_zeros !== 32'd10 || bus.out_nonce !== 32'h55) begin n_err++;
      $display("FAIL bp_first: got v=%0b z=%0d n=%0h expected 1/10/55", bus.out_valid, bus.out_zeros, bus.out_nonce); end
    bus.in_valid = 1'b1; bus.in_hash = mk_hash(3); bus.in_nonce = 32'h66; difficulty = '0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_zeros !== 32'd10 || bus.out_nonce !== 32'h55 || bus.in_ready !== 1'b0) stable = 1'b0;
    end
    n_cmp++; if (!stable) begin n_err++; $display("FAIL bp_hold: got unstable output or in_ready=1, expected held result"); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++;
      $display("FAIL bp_handshake: got v=%0b rdy=%0b expected v=0 rdy=1", bus.out_valid, bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_finish(cyc);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_nonce !== 32'h66 || bus.out_zeros !== 32'd3) begin n_err++;
      $display("FAIL bp_second: got v=%0b n=%0h z=%0d expected 1/66/3", bus.out_valid, bus.out_nonce, bus.out_zeros); end
    @(negedge clk);
    model_finish(10, 32'h55);
    model_finish(3, 32'h66);
    n_cmp++; if (hash_count !== m_cnt) begin n_err++; $display("FAIL bp_count: got %0d expected %0d", hash_count, m_cnt); end
  endtask

  task automatic test_best_ties();
    int cyc; bit q; logic [31:0] z; logic [NONCE_W-1:0] on;
    clear_stats = 1'b1; @(negedge clk); clear_stats = 1'b0;
    model_clear();
    run_hash(mk_hash(20), 32'hA, 32'd300, cyc, q, z, on);
    run_hash(mk_hash(30), 32'hB, 32'd300, cyc, q, z, on);
    run_hash(mk_hash(30), 32'hC, 32'd300, cyc, q, z, on);
    n_cmp++; if (best_zeros !== 32'd30 || best_nonce !== 32'hB || hash_count !== 32'd3) begin n_err++;
      $display("FAIL ties: got best=%0d nonce=%0h cnt=%0d expected 30/B/3", best_zeros, best_nonce, hash_count); end
    clear_stats = 1'b1; @(negedge clk); clear_stats = 1'b0;
    model_clear();
    n_cmp++; if ({best_zeros, best_nonce, hash_count} !== '0) begin n_err++;
      $display("FAIL clear: got best=%0d nonce=%0h cnt=%0d expected 0", best_zeros, best_nonce, hash_count); end
  endtask

  task automatic test_clear_coincident();
    int cyc; bit q; logic [31:0] z; logic [NONCE_W-1:0] on;
    run_hash(mk_hash(100), 32'h77, 32'd0, cyc, q, z, on);
    accept(mk_hash(5), 32'h88, 32'd0);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    model_clear();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_nonce !== 32'h88 || bus.out_zeros !== 32'd5) begin n_err++;
      $display("FAIL coinc_result: got v=%0b n=%0h z=%0d expected 1/88/5", bus.out_valid, bus.out_nonce, bus.out_zeros); end
    n_cmp++; if ({best_zeros, best_nonce, hash_count} !== '0) begin n_err++;
      $display("FAIL coinc_stats: got best=%0d nonce=%0h cnt=%0d expected 0", best_zeros, best_nonce, hash_count); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int cyc; bit q; logic [31:0] z; logic [NONCE_W-1:0] on;
    int lz; logic [31:0] d; logic [NONCE_W-1:0] n; bit exp_q;
    for (int it = 0; it < 24; it++) begin
      lz = ($urandom_range(0, 9) == 0) ? HASH_W : int'($urandom_range(0, HASH_W - 1));
      d  = ($urandom_range(0, 9) == 0) ? $urandom_range(257, 1000) : $urandom_range(0, HASH_W);
      n  = $urandom;
      run_hash(mk_hash(lz), n, d, cyc, q, z, on);
      exp_q = (32'(lz) >= d);
      n_cmp++; if (cyc !== ref_cycles(lz)) begin n_err++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", it, cyc, ref_cycles(lz)); end
      n_cmp++; if (q !== exp_q) begin n_err++; $display("FAIL rnd_qualify[%0d]: got %0b expected %0b (lz=%0d d=%0d)", it, q, exp_q, lz, d); end
      if (exp_q) begin
        n_cmp++; if (z !== 32'(lz) || on !== n) begin n_err++;
          $display("FAIL rnd_result[%0d]: got z=%0d n=%0h expected z=%0d n=%0h", it, z, on, lz, n); end
      end
      n_cmp++; if (best_zeros !== 32'(m_best) || best_nonce !== m_bnonce || hash_count !== m_cnt) begin n_err++;
        $display("FAIL rnd_stats[%0d]: got %0d/%0h/%0d expected %0d/%0h/%0d", it, best_zeros, best_nonce, hash_count, m_best, m_bnonce, m_cnt); end
    end
  endtask

  task automatic test_rst_midscan();
    bit quiet = 1'b1;
    accept('0, 32'h99, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || {best_zeros, best_nonce, hash_count} !== '0) begin n_err++;
      $display("FAIL rst_mid: got v=%0b rdy=%0b best=%0d cnt=%0d expected 0/0/0/0", bus.out_valid, bus.in_ready, best_zeros, hash_count); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %0b expected 1", bus.in_ready); end
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || hash_count !== 32'd0) quiet = 1'b0;
    end
    n_cmp++; if (!quiet) begin n_err++; $display("FAIL rst_mid_discard: got a report or count after reset, expected none"); end
    model_clear();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_diff_miss();
    test_extremes();
    test_backpressure();
    test_best_ties();
    test_clear_coincident();
    test_random();
    test_rst_midscan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
